// File: rtl/number_scan_controller.sv
// number_scan_controller
//   Initiator for a number analyzer: walks an inclusive range one value at a
//   time, hands each value to the analyzer and tallies the odd, Fibonacci and
//   palindrome flags it reports back. All outputs are registered.
//   Optional watchdog on the analyzer handshake: define SCAN_TIMEOUT_EN.
module number_scan_controller #(
  parameter int WIDTH          = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] range_lo,
  input  logic [WIDTH-1:0] range_hi,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [WIDTH-1:0] an_number,
  output logic             an_enable,
  input  logic             an_ready,
  input  logic             an_is_odd,
  input  logic             an_is_fibonacci,
  input  logic             an_is_palindrome,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] odd_count,
  output logic [CNT_W-1:0] fib_count,
  output logic [CNT_W-1:0] pal_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] an_number_q, an_number_d;
  logic             an_enable_q, an_enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] odd_q, odd_d;
  logic [CNT_W-1:0] fib_q, fib_d;
  logic [CNT_W-1:0] pal_q, pal_d;

`ifdef SCAN_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT_CYCLES - 1);
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Saturating increment: a counter that reaches all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    hi_d        = hi_q;
    an_number_d = an_number_q;
    timeout_d   = timeout_q;
    total_d     = total_q;
    odd_d       = odd_q;
    fib_d       = fib_q;
    pal_d       = pal_q;
`ifdef SCAN_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d = '0;
          odd_d   = '0;
          fib_d   = '0;
          pal_d   = '0;
          if (range_lo <= range_hi) begin
            cur_d     = range_lo;
            hi_d      = range_hi;
            timeout_d = 1'b0;
            state_d   = S_ISSUE;
`ifdef SCAN_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end else begin
            // Empty range: report immediately with zeroed counters.
            state_d = S_FIN;
          end
        end
      end
      S_ISSUE: begin
        // Ready is deliberately ignored here: it may still belong to the
        // previous value.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (an_ready) begin
          total_d = sat_inc(total_q, 1'b1);
          odd_d   = sat_inc(odd_q, an_is_odd);
          fib_d   = sat_inc(fib_q, an_is_fibonacci);
          pal_d   = sat_inc(pal_q, an_is_palindrome);
          // Compare before incrementing so an all-ones upper bound never wraps.
          if (cur_q == hi_q) begin
            state_d = S_FIN;
          end else begin
            cur_d   = cur_q + WIDTH'(1);
            state_d = S_GAP;
          end
        end
`ifdef SCAN_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
`endif
      end
      S_GAP: begin
        // One idle enable cycle lets the analyzer re-arm.
        state_d = S_ISSUE;
`ifdef SCAN_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifndef SCAN_TIMEOUT_EN
    // No watchdog in this build; the limit has no meaning here.
    timeout_d = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

    // Outputs follow the state being entered so they are registered.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    an_enable_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    if (state_d == S_ISSUE) begin
      an_number_d = cur_d;
    end
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      hi_q        <= '0;
      an_number_q <= '0;
      an_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      total_q     <= '0;
      odd_q       <= '0;
      fib_q       <= '0;
      pal_q       <= '0;
`ifdef SCAN_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      hi_q        <= hi_d;
      an_number_q <= an_number_d;
      an_enable_q <= an_enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      total_q     <= total_d;
      odd_q       <= odd_d;
      fib_q       <= fib_d;
      pal_q       <= pal_d;
`ifdef SCAN_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign an_number   = an_number_q;
  assign an_enable   = an_enable_q;
  assign total_count = total_q;
  assign odd_count   = odd_q;
  assign fib_count   = fib_q;
  assign pal_count   = pal_q;

endmodule

// File: tb/tb_number_scan_controller.sv
// Bench for number_scan_controller: stub analyzer, a transaction-level model
// that predicts every scan's results, and directed scenarios.
module tb_number_scan_controller;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int TO    = 16;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] range_lo;
  logic [WIDTH-1:0] range_hi;
  logic             busy, done, timeout, an_enable;
  logic [WIDTH-1:0] an_number;
  logic             an_ready, an_is_odd, an_is_fibonacci, an_is_palindrome;
  logic [CNT_W-1:0] total_count, odd_count, fib_count, pal_count;
  logic             stub_mute;
  int               stub_cnt = 0;

  int errors = 0;
  int checks = 0;

  number_scan_controller #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .range_lo(range_lo), .range_hi(range_hi),
    .busy(busy), .done(done), .timeout(timeout),
    .an_number(an_number), .an_enable(an_enable), .an_ready(an_ready),
    .an_is_odd(an_is_odd), .an_is_fibonacci(an_is_fibonacci),
    .an_is_palindrome(an_is_palindrome),
    .total_count(total_count), .odd_count(odd_count),
    .fib_count(fib_count), .pal_count(pal_count)
  );

  always #5 clock = ~clock;

  // Stub analyzer: ready 3 cycles after enable rises, dropped with enable.
  always @(posedge clock) begin
    if (!an_enable) stub_cnt <= 0;
    else            stub_cnt <= stub_cnt + 1;
  end
  assign an_ready         = an_enable && !stub_mute && (stub_cnt >= 3);
  assign an_is_odd        = an_number[0];
  assign an_is_fibonacci  = an_number[1];
  assign an_is_palindrome = an_number[2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  bit          in_scan = 0;
  bit          prev_busy = 0;
  bit          last_en = 0;
  logic [63:0] next_val, held_num;
  longint      rises, busy_cyc;
  longint      exp_tot, exp_odd, exp_fib, exp_pal, exp_busy, exp_rises;
  bit          exp_to = 0;

  function automatic longint sat(input longint v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clock) begin
    #1;
    if (reset) begin
      check("reset_outputs_zero",
            {busy, done, timeout, an_enable, an_number, total_count, odd_count, fib_count, pal_count},
            '0);
      in_scan = 0;
      exp_to  = 0;
    end else begin
      if (start && !prev_busy) begin
        longint unsigned lo64, hi64, n, o, f, p;
        lo64 = range_lo;
        hi64 = range_hi;
        in_scan = 1; rises = 0; busy_cyc = 0; next_val = lo64;
        n = 0; o = 0; f = 0; p = 0;
        if (lo64 <= hi64) begin
          for (longint unsigned v = lo64; v <= hi64; v++) begin
            n++; o += v[0]; f += v[1]; p += v[2];
          end
          exp_to = 0;
          if (stub_mute) begin
            // Analyzer never answers: only the watchdog can end the scan.
            exp_tot = 0; exp_odd = 0; exp_fib = 0; exp_pal = 0;
            exp_rises = 1; exp_busy = 2 + TO; exp_to = 1;
          end else begin
            exp_tot = sat(n); exp_odd = sat(o); exp_fib = sat(f); exp_pal = sat(p);
            exp_rises = n; exp_busy = 5 * n;
          end
        end else begin
          exp_tot = 0; exp_odd = 0; exp_fib = 0; exp_pal = 0;
          exp_rises = 0; exp_busy = 1;
        end
      end
      check("busy_vs_scan", busy, in_scan);
      if (busy) busy_cyc++;
      if (an_enable && !last_en) begin
        check("an_number_issue", an_number, next_val);
        next_val++; rises++; held_num = an_number;
      end else if (an_enable) begin
        check("an_number_hold", an_number, held_num);
      end
      if (done) begin
        check("done_in_scan", in_scan, 1);
        check("total", total_count, exp_tot);
        check("odd", odd_count, exp_odd);
        check("fib", fib_count, exp_fib);
        check("pal", pal_count, exp_pal);
        check("timeout_flag", timeout, exp_to);
        check("busy_cycles", busy_cyc, exp_busy);
        check("enable_windows", rises, exp_rises);
        in_scan = 0;
      end
    end
    prev_busy = busy;
    last_en   = an_enable;
  end

  // ---------------- driver ----------------
  task automatic run_scan(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                          input bit poke, output int lat);
    @(negedge clock);
    range_lo = lo; range_hi = hi; start = 1'b1;
    @(negedge clock);
    start = 1'b0; range_lo = ~lo; range_hi = ~hi;
    lat = 1;
    while (!done && lat < 2000) begin
      @(negedge clock);
      lat++;
      if (poke && lat == 4) begin
        range_lo = 0; range_hi = 1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) check("done_seen", 0, 1);
    @(negedge clock);
    check("idle_after_done", {busy, done}, 2'b00);
  endtask

  task automatic check_counts(input string tag, input int t, input int o, input int f, input int p);
    check({tag, "_total"}, total_count, t);
    check({tag, "_odd"}, odd_count, o);
    check({tag, "_fib"}, fib_count, f);
    check({tag, "_pal"}, pal_count, p);
    $display("%s: total=%0d odd=%0d fib=%0d pal=%0d", tag, total_count, odd_count, fib_count, pal_count);
  endtask

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; range_lo = '0; range_hi = '0; stub_mute = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    run_scan(32'd0, 32'd7, 1'b0, lat);
    check("t1_latency", lat, 40);
    check_counts("t1", 8, 4, 4, 4);

    run_scan(32'd5, 32'd5, 1'b0, lat);
    check("t2_latency", lat, 5);
    check_counts("t2", 1, 1, 0, 1);

    run_scan(32'd9, 32'd3, 1'b0, lat);
    check("t3_latency", lat, 1);
    check_counts("t3", 0, 0, 0, 0);

    run_scan(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, lat);
    check("t4_latency", lat, 10);
    check_counts("t4", 2, 1, 2, 2);

    run_scan(32'd0, 32'd19, 1'b0, lat);
    check_counts("sat", 15, 10, 10, 8);

    // Reset in the middle of a WAIT phase.
    @(negedge clock);
    range_lo = 0; range_hi = 7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    check("t5_in_wait", {busy, an_enable}, 2'b11);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_after_reset",
          {busy, done, an_enable, an_number, total_count}, '0);
    $display("t5: reset mid-scan busy=%0d total=%0d", busy, total_count);
    run_scan(32'd0, 32'd7, 1'b0, lat);
    check_counts("t5_rescan", 8, 4, 4, 4);

    // Analyzer that never answers.
    stub_mute = 1'b1;
`ifdef SCAN_TIMEOUT_EN
    run_scan(32'd10, 32'd12, 1'b0, lat);
    check("t6_latency", lat, 2 + TO);
    check("t6_timeout_sticky", timeout, 1);
    check_counts("t6", 0, 0, 0, 0);
`else
    @(negedge clock);
    range_lo = 10; range_hi = 12; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    begin
      int low_cycles;
      low_cycles = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clock);
        if (!busy || done || timeout) low_cycles++;
      end
      check("t6_busy_held", low_cycles, 0);
      $display("t6: stalled 1000 cycles, busy=%0d timeout=%0d", busy, timeout);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_reset_idle", busy, 0);
`endif
    stub_mute = 1'b0;
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
